// File: rtl/controlador_funcionalidade_pkg.sv
// rtl/controlador_funcionalidade_pkg.sv - shared types, codes and selection decode for the functionality controller
package controlador_funcionalidade_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    EXEC     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [2:0] COD_NONE = 3'b000;
  localparam logic [2:0] COD_A    = 3'b001;
  localparam logic [2:0] COD_B    = 3'b010;
  localparam logic [2:0] COD_C    = 3'b011;
  localparam logic [2:0] COD_D    = 3'b100;
  localparam logic [2:0] COD_E    = 3'b101;
  localparam logic [2:0] COD_F    = 3'b110;
  localparam logic [2:0] COD_G    = 3'b111;

  typedef struct packed {
    logic       one_hot;
    logic [2:0] code;
  } sel_t;

  // Vector order is {A,B,C,D,E,F,G}; anything not exactly one-hot decodes to COD_NONE.
  function automatic sel_t decode_sel(input logic [6:0] sel);
    sel_t r;
    r.one_hot = (sel != 7'd0) && ((sel & (sel - 7'd1)) == 7'd0);
    case (sel)
      7'b1000000: r.code = COD_A;
      7'b0100000: r.code = COD_B;
      7'b0010000: r.code = COD_C;
      7'b0001000: r.code = COD_D;
      7'b0000100: r.code = COD_E;
      7'b0000010: r.code = COD_F;
      7'b0000001: r.code = COD_G;
      default:    r.code = COD_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/controlador_funcionalidade_sincronizador_entrada.sv
// rtl/controlador_funcionalidade_sincronizador_entrada.sv - two-flop synchronizer for the raw selection switches
module sincronizador_entrada #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/controlador_funcionalidade.sv
// rtl/controlador_funcionalidade.sv - debounced one-hot switch selection issuing one functionality command per press
module controlador_funcionalidade
  import controlador_funcionalidade_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic       DONE,
  output logic [2:0] CF,
  output logic       START,
  output logic       BUSY,
  output logic       ERR
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]       s;
  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [6:0]       pat_q, pat_n;
  logic [2:0]       cf_q, cf_n;
  logic             start_q, start_n;
  logic             err_q, err_n;
  sel_t             sel;

  sincronizador_entrada #(.W(7)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({A, B, C, D, E, F, G}),
    .q     (s)
  );

  assign sel = decode_sel(pat_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      cf_q    <= COD_NONE;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pat_q   <= pat_n;
      cf_q    <= cf_n;
      start_q <= start_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pat_n   = pat_q;
    cf_n    = cf_q;
    start_n = 1'b0;
    err_n   = err_q;
    case (state_q)
      IDLE: begin
        if (s != 7'd0) begin
          pat_n   = s;
          cnt_n   = CNT_ONE;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s != pat_q) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt_q < DEB_MAX) begin
          cnt_n = cnt_q + CNT_ONE;
        end else if (sel.one_hot) begin
          cf_n    = sel.code;
          start_n = 1'b1;
          cnt_n   = '0;
          state_n = EXEC;
        end else begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = RELEASE;
        end
      end
      EXEC: begin
        // The START cycle is the first EXEC cycle; DONE only counts after it.
        if (DONE && !start_q) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (s != 7'd0) begin
          cnt_n = '0;
        end else if (cnt_q < DEB_MAX) begin
          cnt_n = cnt_q + CNT_ONE;
        end else begin
          cnt_n   = '0;
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    CF    = cf_q;
    START = start_q;
    ERR   = err_q;
    BUSY  = (state_q == EXEC);
  end

endmodule

// File: tb/tb_controlador_funcionalidade.sv
// tb/tb_controlador_funcionalidade.sv - self-checking bench for controlador_funcionalidade
module tb_controlador_funcionalidade;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic A = 0, B = 0, C = 0, D = 0, E = 0, F = 0, G = 0;
  logic DONE = 1'b0;
  logic [2:0] CF;
  logic START, BUSY, ERR;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int cyc = 0;

  controlador_funcionalidade #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .DONE(DONE), .CF(CF), .START(START), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 clk = ~clk;

  // Reference model: switch samples arrive two edges late; a press needs DEB+1
  // identical nonzero samples, a release needs DEB+1 all-zero samples after the command.
  logic [6:0] m_s1, m_s2;
  int         m_phase;      // 0 waiting for a press, 1 command running, 2 waiting for release
  logic [6:0] m_cand;
  int         m_seen;       // matching samples of m_cand so far (0 = none)
  int         m_zeros;
  logic [2:0] m_cf;
  logic       m_start, m_err;

  function automatic logic [2:0] ref_code(input logic [6:0] v);
    for (int i = 0; i < 7; i++)
      if (v[6-i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_phase = 0; m_cand = 0; m_seen = 0; m_zeros = 0;
    m_cf = 0; m_start = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [6:0] cur;
    logic       was_start;
    cur = m_s2;
    m_s2 = m_s1;
    m_s1 = {A, B, C, D, E, F, G};
    was_start = m_start;
    m_start = 0;
    if (m_phase == 0) begin
      if (m_seen == 0) begin
        if (cur != 0) begin m_cand = cur; m_seen = 1; end
      end else if (cur != m_cand) begin
        m_seen = 0;
      end else if (m_seen < DEB) begin
        m_seen++;
      end else begin
        m_seen = 0;
        m_zeros = 0;
        if ($countones(m_cand) == 1) begin
          m_cf = ref_code(m_cand); m_start = 1; m_phase = 1;
        end else begin
          m_err = 1; m_phase = 2;
        end
      end
    end else if (m_phase == 1) begin
      if (DONE && !was_start) begin m_phase = 2; m_zeros = 0; end
    end else begin
      if (cur != 0) m_zeros = 0;
      else if (m_zeros < DEB) m_zeros++;
      else begin m_phase = 0; m_err = 0; m_zeros = 0; end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else model_step();
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (START) start_cnt++;
    chk("model_cf", int'(CF), int'(m_cf));
    chk("model_start", int'(START), int'(m_start));
    chk("model_busy", int'(BUSY), (m_phase == 1) ? 1 : 0);
    chk("model_err", int'(ERR), int'(m_err));
  end

  task automatic set_sw(input logic [6:0] v);
    {A, B, C, D, E, F, G} = v;
  endtask

  // which: 0 START high, 1 ERR high, 2 ERR low; n = edges taken including the first
  task automatic wait_for(input int which, input int max, output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < max) begin
      @(posedge clk); #1;
      n++;
      hit = (which == 0 && START) || (which == 1 && ERR) || (which == 2 && !ERR);
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL wait_timeout: event %0d not seen within %0d cycles", which, max);
    end
  endtask

  task automatic done_next();
    @(posedge clk); #1 DONE = 1;
    @(posedge clk); #1 DONE = 0;
  endtask

  initial begin
    int n, s0, t1, t2;
    set_sw(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cf", int'(CF), 0);
    chk("reset_start", int'(START), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_err", int'(ERR), 0);
    @(posedge clk); #2 rst_n = 1;
    repeat (3) @(posedge clk);
    #2;

    // Clean press of C
    set_sw(7'b0010000);
    wait_for(0, 30, n);
    chk("clean_latency", n - 1, 6);
    chk("clean_cf", int'(CF), 3);
    chk("clean_busy", int'(BUSY), 1);
    repeat (4) @(posedge clk);
    #1 chk("clean_busy_before_done", int'(BUSY), 1);
    DONE = 1;
    @(posedge clk); #1;
    chk("clean_busy_after_done", int'(BUSY), 0);
    DONE = 0;
    s0 = start_cnt;
    repeat (20) @(posedge clk);
    #1 chk("clean_hold_no_restart", start_cnt - s0, 0);
    set_sw(0);
    repeat (10) @(posedge clk);
    #1;

    // Bouncing D
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      set_sw(7'b0001000);
      repeat (2) @(posedge clk);
      #1 set_sw(0);
      repeat (2) @(posedge clk);
      #1;
    end
    chk("bounce_no_start", start_cnt - s0, 0);
    set_sw(7'b0001000);
    wait_for(0, 30, n);
    chk("bounce_latency", n - 1, 6);
    chk("bounce_cf", int'(CF), 4);
    done_next();
    set_sw(0);
    repeat (10) @(posedge clk);
    #1;

    // Multi-hot A+G
    s0 = start_cnt;
    set_sw(7'b1000001);
    wait_for(1, 30, n);
    chk("multi_err_latency", n - 1, 6);
    chk("multi_no_start", start_cnt - s0, 0);
    chk("multi_cf_kept", int'(CF), 4);
    repeat (5) @(posedge clk);
    #1 chk("multi_err_held", int'(ERR), 1);
    set_sw(0);
    wait_for(2, 30, n);
    chk("multi_err_clear", n - 1, 6);
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back G then B
    set_sw(7'b0000001);
    wait_for(0, 30, n);
    t1 = cyc;
    chk("b2b_cf_g", int'(CF), 7);
    DONE = 1;
    set_sw(0);
    @(posedge clk); #1;
    chk("b2b_done_in_start_ignored", int'(BUSY), 1);
    @(posedge clk); #1;
    chk("b2b_busy_low", int'(BUSY), 0);
    DONE = 0;
    repeat (8) @(posedge clk);
    #1 set_sw(7'b0100000);
    wait_for(0, 30, n);
    t2 = cyc;
    chk("b2b_cf_b", int'(CF), 2);
    chk("b2b_spacing_ok", (t2 - t1 >= 1 + 2 * DEB + 3) ? 1 : 0, 1);
    done_next();
    set_sw(0);
    repeat (10) @(posedge clk);
    #1;

    // Reset in the middle of EXEC
    set_sw(7'b0000100);
    wait_for(0, 30, n);
    chk("rst_first_cf", int'(CF), 5);
    #3 rst_n = 0;
    #1;
    chk("rst_cf_now", int'(CF), 0);
    chk("rst_busy_now", int'(BUSY), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    wait_for(0, 30, n);
    chk("rst_repress_latency", n - 1, 6);
    chk("rst_repress_cf", int'(CF), 5);
    done_next();
    set_sw(0);
    repeat (10) @(posedge clk);
    #1;

    // Randomized patterns and DONE timing against the model
    for (int it = 0; it < 300; it++) begin
      int r, hold;
      logic [6:0] v;
      r = $urandom_range(0, 99);
      if (r < 60) v = 7'(1 << $urandom_range(0, 6));
      else if (r < 75) v = 7'($urandom_range(1, 127)) | 7'(1 << $urandom_range(0, 6)) | 7'b0000001;
      else v = 0;
      if (r >= 60 && r < 75 && $countones(v) < 2) v = v | 7'b1000000;
      set_sw(v);
      hold = $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #2;
        DONE = ($urandom_range(0, 2) == 0);
      end
    end
    set_sw(0);
    DONE = 1;
    repeat (20) @(posedge clk);
    #1 DONE = 0;
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
